// File: rtl/corner_sorter.sv
// Orders four detected corners into TL, TR, BL, BR using the x+y and x-y keys.
// A fixed-latency scan looks at one corner per cycle, then registers the result.
module corner_sorter (
    input  logic        clk,
    input  logic        reset,
    input  logic        corners_ready,
    input  logic [79:0] corners_in,
    output logic [79:0] sorted_corners,
    output logic        degenerate,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [79:0] corners_r;
    logic [1:0]  idx_r;
    logic [1:0]  tl_r, tr_r, bl_r, br_r;
    logic [10:0] tl_key_r, br_key_r, tr_key_r, bl_key_r;
    logic [79:0] sorted_r;
    logic        degenerate_r;
    logic        busy_r;
    logic        done_r;
    logic [19:0] cur_s;
    logic [10:0] key_sum_s;
    logic [10:0] key_diff_s;

    function automatic logic [19:0] pick_corner(input logic [79:0] c, input logic [1:0] i);
        case (i)
            2'd0:    pick_corner = c[79:60];
            2'd1:    pick_corner = c[59:40];
            2'd2:    pick_corner = c[39:20];
            default: pick_corner = c[19:0];
        endcase
    endfunction

    function automatic logic any_equal(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c, input logic [1:0] d);
        any_equal = (a == b) || (a == c) || (a == d) || (b == c) || (b == d) || (c == d);
    endfunction

    // Sort keys of the corner under scan; the 1024 offset keeps x-y non-negative.
    always_comb begin
        cur_s      = pick_corner(corners_r, idx_r);
        key_sum_s  = {1'b0, cur_s[19:10]} + {1'b0, cur_s[9:0]};
        key_diff_s = {1'b0, cur_s[19:10]} - {1'b0, cur_s[9:0]} + 11'd1024;
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (corners_ready) state_s = SCAN;
                else               state_s = IDLE;
            end
            SCAN: begin
                if (idx_r == 2'd3) state_s = CHECK;
                else               state_s = SCAN;
            end
            CHECK:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Capture, running candidate tracking and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            corners_r    <= 80'd0;
            idx_r        <= 2'd0;
            tl_r         <= 2'd0;
            tr_r         <= 2'd0;
            bl_r         <= 2'd0;
            br_r         <= 2'd0;
            tl_key_r     <= 11'd0;
            tr_key_r     <= 11'd0;
            bl_key_r     <= 11'd0;
            br_key_r     <= 11'd0;
            sorted_r     <= 80'd0;
            degenerate_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_r == CHECK);
            case (state_r)
                IDLE: begin
                    if (corners_ready) begin
                        corners_r <= corners_in;
                        idx_r     <= 2'd0;
                    end
                end
                SCAN: begin
                    idx_r <= idx_r + 2'd1;
                    // Strict compares: on a tie the earlier index keeps the slot.
                    if (idx_r == 2'd0 || key_sum_s < tl_key_r) begin
                        tl_r <= idx_r; tl_key_r <= key_sum_s;
                    end
                    if (idx_r == 2'd0 || key_sum_s > br_key_r) begin
                        br_r <= idx_r; br_key_r <= key_sum_s;
                    end
                    if (idx_r == 2'd0 || key_diff_s > tr_key_r) begin
                        tr_r <= idx_r; tr_key_r <= key_diff_s;
                    end
                    if (idx_r == 2'd0 || key_diff_s < bl_key_r) begin
                        bl_r <= idx_r; bl_key_r <= key_diff_s;
                    end
                end
                CHECK: begin
                    sorted_r     <= {pick_corner(corners_r, tl_r), pick_corner(corners_r, tr_r),
                                     pick_corner(corners_r, bl_r), pick_corner(corners_r, br_r)};
                    degenerate_r <= any_equal(tl_r, tr_r, bl_r, br_r);
                end
                default: ;
            endcase
        end
    end

    assign sorted_corners = sorted_r;
    assign degenerate     = degenerate_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule
